// File: rtl/sync_filter_bits.sv
`default_nettype none
// ============================================================================
//  Module   : sync_filter_bits
//  Purpose  : Multi-bit synchronizer and debounce filter. Each of WIDTH
//             independent asynchronous inputs passes through a STAGES-deep
//             synchronizer chain and then a stability filter. d_out[i] only
//             takes the synchronized value after it has differed from d_out[i]
//             for FILTER_LEN consecutive CLK cycles. One-cycle rise/fall
//             pulses mark each accepted transition.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH       number of independent channels (>=1)
//    STAGES      synchronizer flops per channel (>=2)
//    FILTER_LEN  cycles a synced value must persist before acceptance
//                (>=1; 1 = no filtering)
//    INIT        reset value of the sync stages and d_out
//  Ports
//    CLK         in   1      clock; state updates on posedge
//    RST         in   1      synchronous active-high reset
//    async_in    in   WIDTH  asynchronous inputs
//    d_out       out  WIDTH  synchronized, filtered level
//    rise        out  WIDTH  1-cycle pulse on accepted 0->1 of d_out[i]
//    fall        out  WIDTH  1-cycle pulse on accepted 1->0 of d_out[i]
//    any_change  out  1      registered OR of rise|fall, same cycle as pulses
//  Build option
//    SYNC_NEGEDGE_FIRST_EN  when defined, the first sync stage is clocked on
//                           negedge CLK (RST sampled at that negedge), saving
//                           half a cycle of latency at the cost of MTBF.
// ============================================================================
module sync_filter_bits #(
   parameter int               WIDTH      = 4,
   parameter int               STAGES     = 2,
   parameter int               FILTER_LEN = 3,
   parameter logic [WIDTH-1:0] INIT       = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] d_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             any_change
);

   // A 1-deep filter still needs a (degenerate) counter bit to keep the
   // array declarations legal; its only legal value is then 0.
   localparam int             CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

   // ------------------------------------------------------------------------
   // Synchronizer chain. Stage 0 is the only flop that sees the raw
   // asynchronous input; nothing but wires sits between stages.
   // ------------------------------------------------------------------------
   (* async_reg = "true" *) logic [WIDTH-1:0] sync_s0;
   (* async_reg = "true" *) logic [WIDTH-1:0] sync_chain [STAGES-1];
   logic [WIDTH-1:0] synced;

`ifdef SYNC_NEGEDGE_FIRST_EN
   // First stage on the falling edge: half a cycle of resolution time is
   // traded for half a cycle of latency.
   always_ff @(negedge CLK) begin
      if (RST) begin
         sync_s0 <= INIT;
      end else begin
         sync_s0 <= async_in;
      end
   end
`else
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_s0 <= INIT;
      end else begin
         sync_s0 <= async_in;
      end
   end
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k < STAGES - 1; k++) begin
            sync_chain[k] <= INIT;
         end
      end else begin
         sync_chain[0] <= sync_s0;
         for (int k = 1; k < STAGES - 1; k++) begin
            sync_chain[k] <= sync_chain[k-1];
         end
      end
   end

   assign synced = sync_chain[STAGES-2];

   // ------------------------------------------------------------------------
   // Stability filter. Each channel counts consecutive cycles in which the
   // synced value disagrees with d_out; any agreement clears the count, so
   // synced pulses shorter than FILTER_LEN cycles never reach d_out.
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt      [WIDTH];
   logic [CNT_W-1:0] cnt_nxt  [WIDTH];
   logic [WIDTH-1:0] d_nxt;
   logic [WIDTH-1:0] rise_nxt;
   logic [WIDTH-1:0] fall_nxt;
   logic             any_nxt;

   always_comb begin
      d_nxt    = d_out;
      rise_nxt = '0;
      fall_nxt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
         if (synced[i] != d_out[i]) begin
            if (cnt[i] == CNT_MAX) begin
               // Disagreement has now persisted FILTER_LEN cycles: accept.
               d_nxt[i]    = synced[i];
               rise_nxt[i] = synced[i];
               fall_nxt[i] = ~synced[i];
            end else begin
               cnt_nxt[i] = cnt[i] + 1'b1;
            end
         end
      end
      any_nxt = |(rise_nxt | fall_nxt);
   end

   // Pulses are registered alongside d_out so they line up with the new level.
   always_ff @(posedge CLK) begin
      if (RST) begin
         d_out      <= INIT;
         rise       <= '0;
         fall       <= '0;
         any_change <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         d_out      <= d_nxt;
         rise       <= rise_nxt;
         fall       <= fall_nxt;
         any_change <= any_nxt;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

endmodule
`default_nettype wire
